// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, LSB first, one bit per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             s_bit;
  logic             maj;
  logic             last_bit;

  // Full-adder slice on the current LSBs; last_bit marks the final RUN edge
  always_comb begin
    s_bit    = op_a[0] ^ op_b[0] ^ carry;
    maj      = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // State register; reset wins over every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: operand capture in IDLE, one shift/add step per RUN cycle.
  // cout is only written on the last RUN edge so it keeps the previous
  // result's carry while a new addition is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum_r <= '0;
          end
        end
        RUN: begin
          sum_r <= {s_bit, sum_r[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= maj;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            cout_r <= maj;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Present operands at a falling edge and let the next rising edge accept them
  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'hxx; b = 8'hxx; cin = 1'bx;
  endtask

  // Count busy cycles until done is seen (bounded); leaves us at the done negedge
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_with_start: got %b want 0", busy); end
    rst = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++;
    if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
    n_cmp++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
  endtask

  task automatic test_basic();
    int nb;
    bit seen;
    launch(8'h35, 8'h4A, 1'b0);
    wait_done(nb, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL basic_done_seen: got %b want 1", seen); end
    n_cmp++;
    if (nb !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
    n_cmp++;
    if (sum !== 8'h7F) begin n_fail++; $display("FAIL basic_sum: got %h want 7f", sum); end
    n_cmp++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", cout); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b want 0", done); end
    @(negedge clk);
    n_cmp++;
    if (sum !== 8'h7F) begin n_fail++; $display("FAIL basic_sum_hold: got %h want 7f", sum); end
  endtask

  task automatic test_carry();
    int nb;
    bit seen;
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(nb, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL carry1_done_seen: got %b want 1", seen); end
    n_cmp++;
    if (sum !== 8'h00) begin n_fail++; $display("FAIL carry1_sum: got %h want 00", sum); end
    n_cmp++;
    if (cout !== 1'b1) begin n_fail++; $display("FAIL carry1_cout: got %b want 1", cout); end
    @(negedge clk);
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done(nb, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL carry2_done_seen: got %b want 1", seen); end
    n_cmp++;
    if (sum !== 8'hFF) begin n_fail++; $display("FAIL carry2_sum: got %h want ff", sum); end
    n_cmp++;
    if (cout !== 1'b1) begin n_fail++; $display("FAIL carry2_cout: got %b want 1", cout); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int nb;
    bit seen;
    launch(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (cout !== 1'b1) begin n_fail++; $display("FAIL ignore_cout_hold_in_run: got %b want 1", cout); end
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL ignore_done_seen: got %b want 1", seen); end
    n_cmp++;
    if (sum !== 8'h30) begin n_fail++; $display("FAIL ignore_sum: got %h want 30", sum); end
    n_cmp++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL ignore_cout: got %b want 0", cout); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_requeue: got busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    int nb;
    bit seen;
    int ndone;
    launch(8'h55, 8'h55, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_4th_run: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after_rst: got %b want 0", busy); end
    n_cmp++;
    if (sum !== 8'h00) begin n_fail++; $display("FAIL abort_sum_cleared: got %h want 00", sum); end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_cmp++;
    if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    launch(8'h0F, 8'h01, 1'b0);
    wait_done(nb, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL post_abort_done_seen: got %b want 1", seen); end
    n_cmp++;
    if (sum !== 8'h10) begin n_fail++; $display("FAIL post_abort_sum: got %h want 10", sum); end
    n_cmp++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL post_abort_cout: got %b want 0", cout); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h01, 8'h80, 8'hC3};
    logic [7:0] vb [3] = '{8'h02, 8'h80, 8'h3C};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] es [3] = '{8'h03, 8'h01, 8'hFF};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    int t_done [3];
    int nb;
    bit seen;
    a = va[0]; b = vb[0]; cin = vc[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_done(nb, seen);
      t_done[k] = cyc;
      n_cmp++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done_seen[%0d]: got %b want 1", k, seen); end
      n_cmp++;
      if (sum !== es[k]) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %h want %h", k, sum, es[k]); end
      n_cmp++;
      if (cout !== ec[k]) begin n_fail++; $display("FAIL b2b_cout[%0d]: got %b want %b", k, cout, ec[k]); end
      if (k < 2) begin
        a = va[k+1]; b = vb[k+1]; cin = vc[k+1];
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t_done[1] - t_done[0] !== 10) begin n_fail++; $display("FAIL b2b_spacing_01: got %0d want 10", t_done[1] - t_done[0]); end
    n_cmp++;
    if (t_done[2] - t_done[1] !== 10) begin n_fail++; $display("FAIL b2b_spacing_12: got %0d want 10", t_done[2] - t_done[1]); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and sets the operand bit count; legal values are WIDTH >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new addition and is sampled at the rising edge.
REQ-005 a  input  WIDTH  SHALL be operand A, captured when start is accepted.
REQ-006 b  input  WIDTH  SHALL be operand B, captured when start is accepted.
REQ-007 cin  input  1  SHALL be the carry-in, captured when start is accepted.
REQ-008 busy  output  1  SHALL be high while bits are being processed.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  SHALL be the result register.
REQ-011 cout  output  1  SHALL be the final carry-out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: busy=0, done=0; start=1 at an edge SHALL load a->opA, b->opB, cin->carry, clear the bit counter and clear sum, then enter RUN.
REQ-014 RUN, per edge: s = opA[0]^opB[0]^carry; carry <= majority(opA[0], opB[0], carry); s SHALL shift into sum[WIDTH-1] with sum shifting right; opA and opB SHALL shift right with zero fill; counter SHALL increment.
REQ-015 RUN SHALL last exactly WIDTH cycles, with LSB processed first; on the WIDTH-th RUN edge the FSM SHALL enter DONE.
REQ-016 busy SHALL be 1 in RUN only.
REQ-017 DONE: done=1 for exactly one cycle and cout=carry; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 The result SHALL satisfy {cout,sum} = a + b + cin modulo 2^(WIDTH+1), with no overflow flag.
REQ-020 sum and cout SHALL hold their DONE values through IDLE until the next start is accepted; sum is unspecified-partial during RUN, and cout holds its previous value during RUN.
REQ-021 start SHALL be ignored in RUN and DONE, with no queuing and no operand recapture.
REQ-022 A start held high continuously SHALL begin a new operation in each IDLE cycle, so back-to-back operations repeat every WIDTH+2 cycles.
REQ-023 a, b and cin SHALL be don't-care except at the accepting edge.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap during RUN.

Reset
REQ-025 rst=1 at an edge SHALL set state=IDLE, busy=0, done=0, sum=0, cout=0, and clear opA, opB, carry and the counter.
REQ-026 rst SHALL take priority over start and over any FSM transition.
REQ-027 rst asserted during RUN or DONE SHALL abort the operation; done SHALL NOT assert for the aborted operation.

Verification (WIDTH=8)
REQ-028 Apply rst for 2 cycles -> busy=0, done=0, sum=8'h00, cout=0.
REQ-029 start with a=8'h35, b=8'h4A, cin=0 -> busy high for 8 cycles, then done one cycle with sum=8'h7F, cout=0.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; with a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-031 start a=8'h10, b=8'h20, then pulse start during RUN with a=8'hAA -> that pulse is ignored and the result is sum=8'h30, cout=0.
REQ-032 rst on the 4th RUN cycle -> busy=0 next cycle and no done pulse; then start a=8'h0F, b=8'h01 -> sum=8'h10, cout=0.
REQ-033 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart, each with the correct sum.
